// File: rtl/tach_velocity.sv
// Windowed velocity estimator for a 16-bit quadrature position count.
// Publishes the signed per-window delta with direction, stall and overflow status.
module tach_velocity #(
   parameter int unsigned STALL_WINDOWS = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] counth,
   input  logic [7:0] countl,
   input  logic       enable,
   input  logic [15:0] window,
   input  logic       snap,
   output logic [7:0] velh,
   output logic [7:0] vell,
   output logic       vel_valid,
   output logic       dir,
   output logic       stall,
   output logic       ovf
);

   localparam int unsigned POS_W = 16;
   localparam int unsigned ZC_W  = 4;
   localparam logic [POS_W-1:0] MAG_LIMIT = 16'h4000;
   localparam logic [POS_W-1:0] MAG_MIN   = 16'h8000;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_PRIME = 2'd1;
   localparam logic [1:0] S_RUN   = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [POS_W-1:0] timer_q, timer_d;
   logic [POS_W-1:0] base_q, base_d;
   logic [POS_W-1:0] vel_q, vel_d;
   logic [ZC_W-1:0]  zc_q, zc_d;
   logic [7:0]       velh_q, velh_d;
   logic [7:0]       vell_q, vell_d;
   logic             vel_valid_q, vel_valid_d;
   logic             dir_q, dir_d;
   logic             stall_q, stall_d;
   logic             ovf_q, ovf_d;

   logic [POS_W-1:0] pos_c;
   logic [POS_W-1:0] delta_c;
   logic [POS_W-1:0] delta_mag_c;
   logic [POS_W-1:0] prev_mag_c;
   logic             ovf_hit_c;
   logic             publish_c;

   // Delta and trust check against the previously published delta
   always_comb begin
      pos_c       = {counth, countl};
      delta_c     = pos_c - base_q;
      delta_mag_c = delta_c[POS_W-1] ? (16'd0 - delta_c) : delta_c;
      prev_mag_c  = vel_q[POS_W-1] ? (16'd0 - vel_q) : vel_q;
      ovf_hit_c   = (delta_c == MAG_MIN) ||
                    ((delta_c[POS_W-1] != vel_q[POS_W-1]) &&
                     (delta_mag_c > MAG_LIMIT) && (prev_mag_c > MAG_LIMIT));
   end

   // Window sequencer and publish logic
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      base_d      = base_q;
      vel_d       = vel_q;
      zc_d        = zc_q;
      velh_d      = velh_q;
      vell_d      = vell_q;
      vel_valid_d = 1'b0;
      dir_d       = dir_q;
      stall_d     = stall_q;
      ovf_d       = ovf_q;
      publish_c   = 1'b0;

      case (state_q)
         S_IDLE: begin
            zc_d    = '0;
            stall_d = 1'b0;
            if (enable && (window != 16'd0)) begin
               timer_d = window - 16'd1;
               state_d = S_PRIME;
            end
         end
         S_PRIME: begin
            if (!enable) begin
               state_d = S_IDLE;
            end else if (timer_q == 16'd0) begin
               base_d  = pos_c;
               timer_d = window - 16'd1;
               state_d = (window == 16'd0) ? S_IDLE : S_RUN;
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         S_RUN: begin
            if (!enable) begin
               state_d = S_IDLE;
               zc_d    = '0;
               stall_d = 1'b0;
            end else if (timer_q == 16'd0) begin
               publish_c   = 1'b1;
               vel_d       = delta_c;
               dir_d       = delta_c[POS_W-1];
               base_d      = pos_c;
               vel_valid_d = 1'b1;
               timer_d     = window - 16'd1;
               if (delta_c != 16'd0) begin
                  zc_d = '0;
               end else if (zc_q != ZC_W'(STALL_WINDOWS)) begin
                  zc_d = zc_q + ZC_W'(1);
               end
               stall_d = (zc_d == ZC_W'(STALL_WINDOWS));
               if (window == 16'd0) begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q - 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Snapshot reads the pre-publish velocity; an overflow set beats the snap clear
      if (snap) begin
         velh_d = vel_q[15:8];
         vell_d = vel_q[7:0];
      end
      ovf_d = (publish_c && ovf_hit_c) || (ovf_q && !snap);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         base_q      <= '0;
         vel_q       <= '0;
         zc_q        <= '0;
         velh_q      <= '0;
         vell_q      <= '0;
         vel_valid_q <= 1'b0;
         dir_q       <= 1'b0;
         stall_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         base_q      <= base_d;
         vel_q       <= vel_d;
         zc_q        <= zc_d;
         velh_q      <= velh_d;
         vell_q      <= vell_d;
         vel_valid_q <= vel_valid_d;
         dir_q       <= dir_d;
         stall_q     <= stall_d;
         ovf_q       <= ovf_d;
      end
   end

   assign velh      = velh_q;
   assign vell      = vell_q;
   assign vel_valid = vel_valid_q;
   assign dir       = dir_q;
   assign stall     = stall_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_tach_velocity.sv
// Self-checking bench for tach_velocity: directed scenarios plus a random walk,
// compared every cycle against a window-count reference model.
module tb_tach_velocity;

   localparam int unsigned SW = 4;

   logic        clk;
   logic        rst_n;
   logic [7:0]  counth, countl;
   logic        enable;
   logic [15:0] window;
   logic        snap;
   logic [7:0]  velh, vell;
   logic        vel_valid, dir, stall, ovf;

   int checks = 0;
   int errors = 0;

   // Reference model: samples every m_win edges after activation
   bit          m_active;
   int          m_k;
   int          m_win;
   int          m_zc;
   logic [15:0] m_base, m_vel, m_rd;
   logic        m_valid, m_dir, m_stall, m_ovf, m_sampled;

   logic [15:0] pos;

   tach_velocity #(.STALL_WINDOWS(SW)) dut (
      .clk(clk), .rst_n(rst_n), .counth(counth), .countl(countl),
      .enable(enable), .window(window), .snap(snap),
      .velh(velh), .vell(vell), .vel_valid(vel_valid), .dir(dir),
      .stall(stall), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int mag(input logic [15:0] v);
      return v[15] ? (65536 - int'(v)) : int'(v);
   endfunction

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_k = 0; m_win = 0; m_zc = 0;
      m_base = '0; m_vel = '0; m_rd = '0;
      m_valid = 0; m_dir = 0; m_stall = 0; m_ovf = 0; m_sampled = 0;
   endtask

   task automatic check_outputs();
      chk("vel_valid", 16'(vel_valid), 16'(m_valid));
      chk("dir",       16'(dir),       16'(m_dir));
      chk("stall",     16'(stall),     16'(m_stall));
      chk("ovf",       16'(ovf),       16'(m_ovf));
      chk("snapshot",  {velh, vell},   m_rd);
   endtask

   // One clock: drive inputs, advance model at the edge, compare after it
   task automatic step(input logic [15:0] p, input logic en, input logic [15:0] w, input logic sn);
      logic [15:0] old_vel, d;
      bit set;
      counth = p[15:8]; countl = p[7:0]; enable = en; window = w; snap = sn;
      @(posedge clk);
      old_vel = m_vel; set = 0; m_valid = 0; m_sampled = 0;
      if (!en) begin
         m_active = 0; m_zc = 0; m_stall = 0;
      end else if (!m_active) begin
         if (w != 16'd0) begin m_active = 1; m_k = 0; m_win = int'(w); end
      end else begin
         m_k++;
         if (m_k % m_win == 0) begin
            m_sampled = 1;
            if (m_k == m_win) m_base = p;
            else begin
               d = p - m_base;
               set = (d == 16'h8000) ||
                     ((d[15] != old_vel[15]) && (mag(d) > 16384) && (mag(old_vel) > 16384));
               m_vel = d; m_dir = d[15]; m_base = p; m_valid = 1;
               m_zc = (d == 16'd0) ? ((m_zc + 1 > int'(SW)) ? int'(SW) : m_zc + 1) : 0;
               m_stall = (m_zc == int'(SW));
            end
         end
      end
      if (sn) m_rd = old_vel;
      m_ovf = set || (m_ovf && !sn);
      #1;
      check_outputs();
   endtask

   // Hold a position until the next sample edge (prime or publish); snap only on that edge
   task automatic run_win(input logic [15:0] p, input logic [15:0] w, input logic sn);
      int n;
      n = 0;
      do begin
         step(p, 1'b1, w, (sn && m_active && ((m_k + 1) % m_win == 0)) ? 1'b1 : 1'b0);
         n++;
      end while (!m_sampled && n < 100);
      if (!m_sampled) begin
         checks++; errors++;
         $error("FAIL run_win_timeout observed=%0d expected=<100", n);
      end
      pos = p;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(pos, 1'b0, window, 1'b0);
   endtask

   initial begin
      int first_n;
      rst_n = 1'b0; counth = '0; countl = '0; enable = 1'b0; window = '0; snap = 1'b0;
      pos = '0;
      model_reset();

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check_outputs();
      rst_n = 1'b1;

      // window = 0 keeps the block idle
      for (int i = 0; i < 100; i++) step(16'd0, 1'b1, 16'd0, 1'b0);

      // Forward ramp: +1 every 2 cycles, window 10
      first_n = -1;
      step(16'd0, 1'b1, 16'd10, 1'b0);
      for (int n = 1; n <= 60; n++) begin
         step(16'(n / 2), 1'b1, 16'd10, 1'b0);
         if (vel_valid && first_n < 0) first_n = n;
      end
      chk("first_publish_latency", 16'(first_n), 16'd20);
      step(16'd30, 1'b1, 16'd10, 1'b1);
      chk("fwd_snapshot", {velh, vell}, 16'h0005);
      chk("fwd_dir", 16'(dir), 16'd0);
      pos = 16'd30;
      idle(3);

      // Reverse across zero: 0x0003 -> 0xFFFC
      step(16'd0, 1'b1, 16'd0, 1'b1);   // clear any sticky ovf before the scenario
      pos = 16'd0;
      run_win(16'h0003, 16'd6, 1'b0);
      run_win(16'hFFFC, 16'd6, 1'b0);
      step(16'hFFFC, 1'b1, 16'd6, 1'b1);
      chk("rev_snapshot", {velh, vell}, 16'hFFF9);
      chk("rev_dir", 16'(dir), 16'd1);
      chk("rev_ovf", 16'(ovf), 16'd0);

      // Snap coincident with publish keeps the old velocity
      run_win(16'hFFFE, 16'd6, 1'b1);
      chk("collision_snapshot", {velh, vell}, 16'hFFF9);
      step(16'hFFFE, 1'b1, 16'd6, 1'b1);
      chk("after_collision_snapshot", {velh, vell}, 16'h0002);

      // Asynchronous reset mid-window, then re-prime
      step(16'hFFFE, 1'b1, 16'd6, 1'b0);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      #1 rst_n = 1'b1;
      first_n = -1;
      for (int n = 1; n <= 40 && first_n < 0; n++) begin
         step(16'(16'h0100 + 16'(n)), 1'b1, 16'd6, 1'b0);
         if (vel_valid) first_n = n;
      end
      chk("post_reset_publish", 16'(first_n), 16'd13);
      pos = 16'h0200;
      idle(3);

      // Stall after four zero-delta publishes, clears on a count step
      run_win(16'h1234, 16'd3, 1'b0);
      for (int i = 0; i < 3; i++) run_win(16'h1234, 16'd3, 1'b0);
      chk("stall_before_4th", 16'(stall), 16'd0);
      run_win(16'h1234, 16'd3, 1'b0);
      chk("stall_at_4th", 16'(stall), 16'd1);
      run_win(16'h1235, 16'd3, 1'b0);
      chk("stall_cleared", 16'(stall), 16'd0);
      idle(3);

      // Overflow: +0x5000 then -0x5000, then a third flip with a coincident snap
      run_win(16'h0100, 16'd4, 1'b0);
      run_win(16'h5100, 16'd4, 1'b0);
      chk("ovf_after_first", 16'(ovf), 16'd0);
      run_win(16'h0100, 16'd4, 1'b0);
      chk("ovf_after_flip", 16'(ovf), 16'd1);
      run_win(16'h5100, 16'd4, 1'b1);
      chk("ovf_set_beats_snap", 16'(ovf), 16'd1);
      chk("ovf_snap_old_vel", {velh, vell}, 16'hB000);
      step(16'h5100, 1'b1, 16'd4, 1'b1);
      chk("ovf_clean_snap", 16'(ovf), 16'd0);
      chk("ovf_clean_snapshot", {velh, vell}, 16'h5000);
      idle(2);

      // Random walk with occasional jumps, enable drops and window changes
      window = 16'(1 + $urandom_range(0, 11));
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            window = 16'(1 + $urandom_range(0, 11));
            idle(1 + int'($urandom_range(0, 3)));
         end else begin
            if ($urandom_range(0, 39) == 0) pos = 16'($urandom);
            else pos = pos + 16'($urandom_range(0, 6)) - 16'd3;
            step(pos, 1'b1, window, ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tach_velocity.md
# tach_velocity

Velocity estimator sitting directly downstream of the quadrature tach counter. It samples the 16-bit position count at a programmable window and computes the signed per-window position delta, modulo 2^16. It publishes that delta as a velocity word, together with direction, stall and overflow status. An 8-bit byte-snapshot path lets the host read the 16-bit velocity coherently over the 8-bit register bus.

## Interface
- STALL_WINDOWS, 4: consecutive zero-delta windows before `stall` asserts (1..15).
- clk  in  1  system clock, shared with the tach counter
- rst_n  in  1  asynchronous active-low reset
- counth  in  8  tach counter high byte, synchronous to clk
- countl  in  8  tach counter low byte, synchronous to clk
- enable  in  1  run the window timer; low holds the block idle
- window  in  16  window length in clk cycles; 0 = no sampling
- snap  in  1  one-cycle strobe: copy the current velocity into the read bytes
- velh  out  8  snapshot velocity high byte
- vell  out  8  snapshot velocity low byte
- vel_valid  out  1  one-cycle pulse when a new velocity is published
- dir  out  1  1 = last published velocity negative
- stall  out  1  no count change for STALL_WINDOWS windows
- ovf  out  1  sticky flag for a delta magnitude that cannot be trusted; cleared by `snap`

## Operation
- Position: pos = {counth, countl}.
- States:
  - IDLE: entered at reset, whenever `enable`=0, and whenever `window`=0. On `enable`=1 and `window`≠0: load timer = window−1, go to PRIME.
  - PRIME: timer decrements each cycle. At timer==0: base ← pos, reload timer, go to RUN. No publish happens in PRIME.
  - RUN: timer decrements each cycle. At timer==0:
    - delta = pos − base, 16-bit modulo, interpreted as two's complement;
    - vel ← delta; base ← pos; reload timer; pulse `vel_valid`;
    - stay in RUN.
- `enable` falling in any state: go to IDLE next cycle. Timer, base and the stall counter are discarded. `vel`, `velh`, `vell` and `ovf` are retained.
- `window` changes take effect only at the next timer reload.
- Direction: `dir` ← delta[15] on each publish.
- Stall: counter zc counts consecutive publishes with delta==0 and saturates at STALL_WINDOWS. Any nonzero delta clears zc. `stall` = (zc == STALL_WINDOWS). Leaving RUN clears zc and `stall`.
- Overflow: on publish, if delta == 16'h8000, or sign(delta) ≠ sign(previous delta) with both |delta| > 16'h4000, set `ovf`. Sticky until a `snap`.
- Snapshot: on `snap`, {velh, vell} ← vel and `ovf` clears.
  - If `snap` and a publish occur in the same cycle, the snapshot takes the pre-publish vel.
  - If `snap` and an overflow set occur in the same cycle, set wins and `ovf` stays 1.

## Timing
- Reset values: velh=0, vell=0, vel_valid=0, dir=0, stall=0, ovf=0, internal vel=0, state=IDLE.
- The window is exactly `window` cycles: consecutive samples are `window` clk edges apart.
- The first sample (PRIME) is taken `window` cycles after the cycle `enable` is seen high in IDLE. The first publish comes `window` cycles after that.
- Publish latency: pos is sampled at edge T. `vel`, `dir`, `stall`, `ovf` and the `vel_valid` pulse are all visible after edge T. `vel_valid` is high for exactly one cycle.
- `velh`/`vell` change only on the edge following a `snap` assertion. The reset is the only other source of change.
- `rst_n` asserted mid-window: all state and outputs go to reset values immediately. After release, the block re-primes; no stale delta is ever published.
- Registered outputs have no combinational path from inputs.

## Test plan
- Reset and idle: rst_n low, then enable=1, window=0 for 100 cycles → no `vel_valid`, all outputs 0.
- Forward count: window=10, count ramps +1 every 2 cycles → first `vel_valid` 20 cycles after enable. Snap → velh:vell = 0x0005, dir=0.
- Reverse with wrap: base 0x0003, count decrements by 7 across 0x0000 within the window → vel = 0xFFF9, dir=1, ovf=0.
- Stall: STALL_WINDOWS=4, count frozen → `stall` rises on the 4th zero publish. One count step → `stall` drops on the next publish.
- Overflow: delta 0x5000 then 0xB000 → `ovf`=1 after the second publish. `snap` in the same cycle as a third overflow publish → ovf stays 1. A later clean snap → ovf=0.
- Collision and reset: snap coincident with publish → read bytes hold the old vel. rst_n pulse mid-window → outputs zero at once, and the next publish occurs 2×window after release.
